// File: rtl/csr_unit_pkg.sv
// csr_defs: CSR numbers, exception codes, field positions and the masked-write helper.
package csr_defs;

    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0C;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_SAVE1  = 14'h31;
    localparam logic [13:0] CSR_SAVE2  = 14'h32;
    localparam logic [13:0] CSR_SAVE3  = 14'h33;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam int CRMD_IE        = 2;
    localparam int ESTAT_TI       = 11;
    localparam int ESTAT_ECODE    = 16;
    localparam int ESTAT_ESUB     = 22;
    localparam int TCFG_EN        = 0;
    localparam int TCFG_PERIODIC  = 1;

    // Bits software may change; everything else stays 0.
    localparam logic [31:0] CRMD_WMASK   = 32'h0000_000F;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wmask,
                                          input logic [31:0] wvalue);
        return (old & ~wmask) | (wvalue & wmask);
    endfunction

endpackage

// File: rtl/csr_unit_timer.sv
// csr_timer: TCFG/TVAL constant timer, emits a one-cycle TI-set pulse when TVAL reaches 0.
module csr_timer import csr_defs::*; (
    input  logic        clk,
    input  logic        reset,
    input  logic        tcfg_we,
    input  logic [31:0] wmask,
    input  logic [31:0] wvalue,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        ti_set
);
    logic [31:0] tcfg_new;

    assign tcfg_new = merge(tcfg, wmask, wvalue);
    assign ti_set   = ~tcfg_we & tcfg[TCFG_EN] & (tval == 32'd0);

    // All-ones is the one-shot parked state: it never decrements further.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg <= 32'd0;
            tval <= 32'd0;
        end else if (tcfg_we) begin
            tcfg <= tcfg_new;
            tval <= {tcfg_new[31:2], 2'b00};
        end else if (tcfg[TCFG_EN]) begin
            if (tval == 32'd0)
                tval <= tcfg[TCFG_PERIODIC] ? {tcfg[31:2], 2'b00} : 32'hFFFF_FFFF;
            else if (tval != 32'hFFFF_FFFF)
                tval <= tval - 32'd1;
        end
    end
endmodule

// File: rtl/csr_unit.sv
// csr_unit: LoongArch CSR file with exception/ertn updates, interrupt status and timer.
module csr_unit import csr_defs::*; #(
    parameter logic [31:0] CORE_ID = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);
    logic [31:0] crmd, prmd, ecfg, estat, era, badv, eentry, tid, tcfg, tval;
    logic [31:0] save [4];
    logic [31:0] cur, merged;
    logic        we, ticlr, ti_set;

    // Exception and ertn take precedence and swallow any same-cycle CSR write.
    assign we     = csr_we & ~wb_ex & ~ertn_flush;
    assign ticlr  = we & (csr_num == CSR_TICLR) & csr_wmask[0] & csr_wvalue[0];
    assign merged = merge(cur, csr_wmask, csr_wvalue);

    always_comb begin
        cur = 32'd0;
        case (csr_num)
            CSR_CRMD:   cur = crmd;
            CSR_PRMD:   cur = prmd;
            CSR_ECFG:   cur = ecfg;
            CSR_ESTAT:  cur = estat;
            CSR_ERA:    cur = era;
            CSR_BADV:   cur = badv;
            CSR_EENTRY: cur = eentry;
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: cur = save[csr_num[1:0]];
            CSR_TID:    cur = tid;
            CSR_TCFG:   cur = tcfg;
            CSR_TVAL:   cur = tval;
            default:    cur = 32'd0;
        endcase
    end

    assign csr_rvalue = csr_re ? cur : 32'd0;
    assign ex_entry   = {eentry[31:6], 6'b0};
    assign ertn_entry = era;
    assign has_int    = crmd[CRMD_IE] & |(estat[12:0] & ecfg[12:0]);

    csr_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .tcfg_we(we & (csr_num == CSR_TCFG)),
        .wmask  (csr_wmask),
        .wvalue (csr_wvalue),
        .tcfg   (tcfg),
        .tval   (tval),
        .ti_set (ti_set)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd   <= 32'h8;
            prmd   <= 32'd0;
            ecfg   <= 32'd0;
            estat  <= 32'd0;
            era    <= 32'd0;
            badv   <= 32'd0;
            eentry <= 32'd0;
            tid    <= CORE_ID;
            for (int i = 0; i < 4; i++) save[i] <= 32'd0;
        end else begin
            if (wb_ex) begin
                prmd       <= {29'd0, crmd[2:0]};
                crmd[2:0]  <= 3'b000;
                era        <= wb_pc;
                estat[ESTAT_ECODE +: 6] <= wb_ecode;
                estat[ESTAT_ESUB +: 9]  <= wb_esubcode;
                if (wb_ecode == ECODE_ADE) badv <= wb_pc;
                else if (wb_ecode == ECODE_ALE) badv <= wb_vaddr;
            end else if (ertn_flush) begin
                crmd[2:0] <= prmd[2:0];
            end else if (we) begin
                case (csr_num)
                    CSR_CRMD:   crmd   <= merged & CRMD_WMASK;
                    CSR_PRMD:   prmd   <= merged & PRMD_WMASK;
                    CSR_ECFG:   ecfg   <= merged & ECFG_WMASK;
                    CSR_ESTAT:  estat[1:0] <= merged[1:0];
                    CSR_ERA:    era    <= merged;
                    CSR_BADV:   badv   <= merged;
                    CSR_EENTRY: eentry <= merged & EENTRY_WMASK;
                    CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: save[csr_num[1:0]] <= merged;
                    CSR_TID:    tid    <= merged;
                    default:    ;
                endcase
            end
            // A timer set in the same cycle as a TICLR clear wins.
            estat[12:2] <= {ipi_int_in, ti_set | (estat[ESTAT_TI] & ~ticlr), 1'b0, hw_int_in};
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed test-plan sequence plus randomized traffic checked against a field-level model.
module tb_csr_unit;
    localparam logic [31:0] CORE_ID = 32'h0;

    logic        clk = 1'b0, reset = 1'b1;
    logic        csr_re = 1'b0, csr_we = 1'b0, wb_ex = 1'b0, ertn_flush = 1'b0, ipi_int_in = 1'b0;
    logic [13:0] csr_num = '0;
    logic [31:0] csr_wmask = '0, csr_wvalue = '0, wb_pc = '0, wb_vaddr = '0;
    logic [5:0]  wb_ecode = '0;
    logic [8:0]  wb_esubcode = '0;
    logic [7:0]  hw_int_in = '0;
    logic [31:0] csr_rvalue, ex_entry, ertn_entry;
    logic        has_int;

    csr_unit #(.CORE_ID(CORE_ID)) dut (
        .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int)
    );

    always #10 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural state held as individual fields.
    logic [1:0]  m_plv, m_pplv, m_sw;
    logic        m_ie, m_da, m_pie, m_ipi, m_ti;
    logic [12:0] m_lie;
    logic [7:0]  m_hw;
    logic [5:0]  m_ecode;
    logic [8:0]  m_esub;
    logic [31:0] m_era, m_badv, m_eentry, m_tid, m_tcfg, m_tval;
    logic [31:0] m_save [4];

    function automatic logic [31:0] m_read(input logic [13:0] n);
        case (n)
            14'h00: return {28'd0, m_da, m_ie, m_plv};
            14'h01: return {29'd0, m_pie, m_pplv};
            14'h04: return {19'd0, m_lie};
            14'h05: return {1'b0, m_esub, m_ecode, 3'b0, m_ipi, m_ti, 1'b0, m_hw, m_sw};
            14'h06: return m_era;
            14'h07: return m_badv;
            14'h0C: return m_eentry;
            14'h30, 14'h31, 14'h32, 14'h33: return m_save[n - 14'h30];
            14'h40: return m_tid;
            14'h41: return m_tcfg;
            14'h42: return m_tval;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_has_int();
        logic [12:0] is_bits = {m_ipi, m_ti, 1'b0, m_hw, m_sw};
        return m_ie && ((is_bits & m_lie) != 13'd0);
    endfunction

    task automatic model_reset();
        {m_plv, m_pplv, m_sw, m_ie, m_pie, m_ipi, m_ti, m_lie, m_hw, m_ecode, m_esub} = '0;
        m_da = 1'b1;
        m_era = 0; m_badv = 0; m_eentry = 0; m_tid = CORE_ID; m_tcfg = 0; m_tval = 0;
        for (int i = 0; i < 4; i++) m_save[i] = 0;
    endtask

    task automatic model_step();
        logic [31:0] r;
        logic wr, tset = 1'b0, ticlr = 1'b0;
        if (reset) begin
            model_reset();
            return;
        end
        wr = csr_we && !wb_ex && !ertn_flush;
        if (!(wr && csr_num == 14'h41) && m_tcfg[0]) begin
            if (m_tval == 0) begin
                tset = 1'b1;
                m_tval = m_tcfg[1] ? {m_tcfg[31:2], 2'b00} : 32'hFFFF_FFFF;
            end else if (m_tval != 32'hFFFF_FFFF) m_tval = m_tval - 1;
        end
        if (wb_ex) begin
            m_pplv = m_plv; m_pie = m_ie; m_plv = 0; m_ie = 0;
            m_era = wb_pc; m_ecode = wb_ecode; m_esub = wb_esubcode;
            if (wb_ecode == 6'h08) m_badv = wb_pc;
            if (wb_ecode == 6'h09) m_badv = wb_vaddr;
        end else if (ertn_flush) begin
            m_plv = m_pplv; m_ie = m_pie;
        end else if (wr) begin
            r = (m_read(csr_num) & ~csr_wmask) | (csr_wvalue & csr_wmask);
            case (csr_num)
                14'h00: {m_da, m_ie, m_plv} = r[3:0];
                14'h01: {m_pie, m_pplv} = r[2:0];
                14'h04: m_lie = r[12:0] & 13'h1BFF;
                14'h05: m_sw = r[1:0];
                14'h06: m_era = r;
                14'h07: m_badv = r;
                14'h0C: m_eentry = r & 32'hFFFF_FFC0;
                14'h30, 14'h31, 14'h32, 14'h33: m_save[csr_num - 14'h30] = r;
                14'h40: m_tid = r;
                14'h41: begin m_tcfg = r; m_tval = {r[31:2], 2'b00}; end
                14'h44: ticlr = csr_wmask[0] & csr_wvalue[0];
                default: ;
            endcase
        end
        m_ti = tset ? 1'b1 : (ticlr ? 1'b0 : m_ti);
        m_hw = hw_int_in;
        m_ipi = ipi_int_in;
    endtask

    task automatic tick();
        #1;
        check("rvalue", csr_rvalue, csr_re ? m_read(csr_num) : 32'd0);
        check("has_int", {31'd0, has_int}, {31'd0, m_has_int()});
        check("ex_entry", ex_entry, {m_eentry[31:6], 6'b0});
        check("ertn_entry", ertn_entry, m_era);
        model_step();
        @(posedge clk);
        #1;
        csr_re = 0; csr_we = 0; wb_ex = 0; ertn_flush = 0;
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1; csr_num = n; csr_wmask = m; csr_wvalue = v;
        tick();
    endtask

    task automatic expect_rd(input string tag, input logic [13:0] n, input logic [31:0] e);
        csr_re = 1; csr_num = n;
        #1;
        check(tag, csr_rvalue, e);
        csr_re = 0;
    endtask

    logic [13:0] nums [16] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C, 14'h30,
                               14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02};
    logic [5:0]  codes [7] = '{6'h00, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h3F};

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        model_reset();
        #1;
        check("rst_rvalue", csr_rvalue, 32'd0);
        check("rst_ex_entry", ex_entry, 32'd0);
        check("rst_ertn_entry", ertn_entry, 32'd0);
        check("rst_has_int", {31'd0, has_int}, 32'd0);
        expect_rd("rst_crmd", 14'h00, 32'h8);
        expect_rd("rst_tid", 14'h40, CORE_ID);
        expect_rd("rst_estat", 14'h05, 32'd0);

        wr(14'h00, 32'h7, 32'h7);
        expect_rd("crmd_set", 14'h00, 32'hF);
        wb_ex = 1; wb_ecode = 6'h0B; wb_esubcode = 0; wb_pc = 32'h1C00_0100;
        tick();
        expect_rd("sys_estat", 14'h05, 32'h000B_0000);
        expect_rd("sys_era", 14'h06, 32'h1C00_0100);
        expect_rd("sys_prmd", 14'h01, 32'h7);
        expect_rd("sys_crmd", 14'h00, 32'h8);
        check("sys_ertn_entry", ertn_entry, 32'h1C00_0100);
        ertn_flush = 1;
        tick();
        expect_rd("ertn_crmd", 14'h00, 32'hF);

        wb_ex = 1; wb_ecode = 6'h09; wb_pc = 32'h1C00_0200; wb_vaddr = 32'h13;
        csr_we = 1; csr_num = 14'h30; csr_wmask = '1; csr_wvalue = 32'hDEAD_BEEF;
        tick();
        expect_rd("ale_badv", 14'h07, 32'h13);
        expect_rd("ale_save0", 14'h30, 32'd0);

        wr(14'h0C, 32'hFFFF_FFFF, 32'h1C00_8040);
        #1 check("eentry", ex_entry, 32'h1C00_8040);
        wr(14'h31, 32'h0000_FFFF, 32'hFFFF_FFFF);
        expect_rd("save1_mask", 14'h31, 32'h0000_FFFF);

        wr(14'h04, '1, 32'h800);
        wr(14'h00, 32'h4, 32'h4);
        wr(14'h41, '1, 32'hB);
        expect_rd("tval_load", 14'h42, 32'h8);
        repeat (8) tick();
        expect_rd("tval_zero", 14'h42, 32'h0);
        check("ti_not_yet", {31'd0, has_int}, 32'd0);
        tick();
        #1 check("ti_has_int", {31'd0, has_int}, 32'd1);
        expect_rd("tval_reload", 14'h42, 32'h8);
        csr_re = 1; csr_num = 14'h05;
        #1 check("ti_bit", {31'd0, csr_rvalue[11]}, 32'd1);
        wr(14'h44, 32'h1, 32'h1);
        #1 check("ticlr_has_int", {31'd0, has_int}, 32'd0);
        wr(14'h41, '1, 32'h0);

        wr(14'h04, '1, 32'h4);
        hw_int_in = 8'h01;
        #1 check("hw_lat0", {31'd0, has_int}, 32'd0);
        tick();
        #1 check("hw_lat1", {31'd0, has_int}, 32'd1);
        wr(14'h00, 32'h4, 32'h0);
        #1 check("hw_ie0", {31'd0, has_int}, 32'd0);
        hw_int_in = 0;
        tick();

        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(99) == 0);
            csr_re = $urandom_range(1);
            csr_num = nums[$urandom_range(15)];
            csr_we = ($urandom_range(2) == 0);
            csr_wmask = $urandom_range(1) ? 32'hFFFF_FFFF : $urandom;
            csr_wvalue = (csr_num == 14'h41) ? ($urandom & 32'h3F) : $urandom;
            wb_ex = ($urandom_range(15) == 0);
            ertn_flush = ($urandom_range(15) == 0);
            wb_ecode = codes[$urandom_range(6)];
            wb_esubcode = 9'($urandom);
            wb_pc = $urandom;
            wb_vaddr = $urandom;
            if ($urandom_range(7) == 0) hw_int_in = 8'($urandom);
            if ($urandom_range(7) == 0) ipi_int_in = $urandom_range(1);
            tick();
            reset = 0;
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
# csr_unit

Control/status register file for the LoongArch pipeline, sitting beside the write-back stage. It is the receiving end of the write-back exception interface. It consumes `wb_ex`/`wb_ecode`/`wb_esubcode`/`wb_pc` and `ertn_flush`, performs the architectural CRMD/PRMD/ESTAT/ERA/BADV updates, and returns the redirect targets (`ex_entry`, `ertn_entry`). It also serves csrrd/csrwr/csrxchg accesses, runs the constant timer, and raises `has_int` back to the pipeline.

## Interface
- CORE_ID, 32'h0, reset value of TID.

- clk  input  1  core clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- csr_re  input  1  read enable.
- csr_num  input  14  CSR address for read and write.
- csr_rvalue  output  32  read data.
- csr_we  input  1  write enable.
- csr_wmask  input  32  per-bit write mask.
- csr_wvalue  input  32  write data.
- wb_ex  input  1  exception commit from write-back.
- wb_ecode  input  6  exception code.
- wb_esubcode  input  9  exception subcode.
- wb_pc  input  32  PC of the faulting instruction.
- wb_vaddr  input  32  faulting data address (ALE).
- ertn_flush  input  1  ertn commit.
- hw_int_in  input  8  hardware interrupt lines.
- ipi_int_in  input  1  inter-processor interrupt.
- ex_entry  output  32  exception target (EENTRY).
- ertn_entry  output  32  return target (ERA).
- has_int  output  1  pending enabled interrupt.

## Operation
- Registers and fields:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3].
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[9:0], LIE[12:11].
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22].
  - ERA 0x6.
  - BADV 0x7.
  - EENTRY 0xC: VA[31:6].
  - SAVE0–3 0x30–0x33.
  - TID 0x40.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only.
  - TICLR 0x44: write-only; reads as 0.
- Unlisted or reserved bits read 0 and ignore writes.
- Masked write rule: new = (old & ~wmask) | (wvalue & wmask), restricted to writable bits.
  - Software-writable ESTAT bits: IS[1:0] only.
- Read: `csr_rvalue` = selected register when `csr_re`=1, else 0. An unknown `csr_num` reads 0.
- Exception (`wb_ex`=1):
  - PRMD.PPLV←CRMD.PLV; PRMD.PIE←CRMD.IE.
  - CRMD.PLV←0; CRMD.IE←0.
  - ERA←wb_pc.
  - ESTAT.Ecode←wb_ecode; ESTAT.EsubCode←wb_esubcode.
  - BADV←wb_pc for ecode 0x08 (ADE); BADV←wb_vaddr for 0x09 (ALE); BADV unchanged otherwise.
- ertn (`ertn_flush`=1): CRMD.PLV←PRMD.PPLV; CRMD.IE←PRMD.PIE.
- Priority in the same cycle: `wb_ex` > `ertn_flush` > `csr_we`. The lower-priority requests are discarded entirely.
- Interrupt sampling: IS[9:2]←hw_int_in and IS[12]←ipi_int_in, registered every cycle.
- IS[11] (TI) handling:
  - Set by the timer.
  - Cleared by a TICLR write with wmask[0]&wvalue[0]=1.
  - A simultaneous set and clear leaves TI set.
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
- Timer:
  - A TCFG write loads TVAL←{InitVal,2'b00}, taken from the new value.
  - Otherwise, when En=1:
    - TVAL≠0 and TVAL≠32'hFFFF_FFFF: decrement.
    - TVAL=0: set TI. If Periodic, reload {InitVal,2'b00}; else TVAL←32'hFFFF_FFFF and hold.
  - En=0 freezes TVAL.
- Outputs `ex_entry`={EENTRY.VA,6'b0} and `ertn_entry`=ERA are always driven.

## Timing
- Reset values:
  - CRMD=32'h8 (DA=1).
  - TID=CORE_ID.
  - All other registers and TVAL=0.
  - Outputs: csr_rvalue=0, ex_entry=0, ertn_entry=0, has_int=0.
- Read is combinational, zero latency. A write in cycle N is visible to reads in cycle N+1; a read in cycle N returns the old value.
- `wb_ex` and `ertn_flush` are single-cycle pulses; state updates at the next edge. `ex_entry` and `ertn_entry` are combinational from the current registers, so the pipeline samples them in the same cycle as the pulse.
- hw_int_in → has_int latency: 1 cycle.
- Timer expiry → TI set: 1 cycle after TVAL=0 is observed. TVAL counts InitVal×4, then 0, then reload or halt.
- Reset mid-count restores the reset values in one cycle. There are no multi-cycle states.

## Structure
- Package `csr_defs` holds:
  - CSR number localparams.
  - ECODE constants: INT 0x00, ADE 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D, TLBR 0x3F.
  - Field bit-position constants.
- Sub-module `csr_timer` holds TCFG, TVAL and the TI-set pulse. `csr_unit` owns all other registers and the TI clear.

## Test plan
- Reset, then read 0x0 and 0x40 → 32'h8 and CORE_ID; read 0x5 → 0.
- Set CRMD=0x7. Pulse wb_ex with ecode=0x0B and wb_pc=32'h1C00_0100 → ESTAT[21:16]=0x0B, ERA=32'h1C00_0100, PRMD=0x7, CRMD=0x8. Then ertn_flush → CRMD=0xF.
- ALE: pulse wb_ex with ecode=0x09 and wb_vaddr=32'h0000_0013 → BADV=32'h13. Same cycle csr_we to SAVE0 → SAVE0 unchanged.
- Write EENTRY=32'h1C00_8040 with wmask all-ones → ex_entry=32'h1C00_8040. Masked write of SAVE1 with wmask=32'h0000_FFFF and wvalue=32'hFFFF_FFFF over 0 → 32'h0000_FFFF.
- Timer:
  - Write TCFG=32'h0000_000B (InitVal=2, periodic, En) → TVAL reads 8, then counts to 0 and TI sets.
  - With ECFG.LIE[11]=1 and CRMD.IE=1 → has_int=1; TVAL reloads to 8.
  - TICLR write 1 → TI clears and has_int=0.
- Drive hw_int_in=8'h01 with LIE[2]=1 and IE=1 → has_int rises exactly 1 cycle later. With IE=0 → has_int stays 0.
